// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types, one-hot instruction bit positions and memop decode
// for the memory-access stage.
package mem_stage_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [3:0] {
    MOP_NONE, MOP_LB, MOP_LH, MOP_LW, MOP_LBU, MOP_LHU, MOP_SB, MOP_SH, MOP_SW
  } memop_t;
  localparam int INST_W   = 64;
  localparam int INST_ADD = 0;
  localparam int INST_LB  = 20;
  localparam int INST_LH  = 21;
  localparam int INST_LW  = 22;
  localparam int INST_LBU = 23;
  localparam int INST_LHU = 24;
  localparam int INST_SB  = 25;
  localparam int INST_SH  = 26;
  localparam int INST_SW  = 27;
  function automatic memop_t decode_memop(input logic [INST_W-1:0] inst);
    return inst[INST_LB]  ? MOP_LB  :
           inst[INST_LH]  ? MOP_LH  :
           inst[INST_LW]  ? MOP_LW  :
           inst[INST_LBU] ? MOP_LBU :
           inst[INST_LHU] ? MOP_LHU :
           inst[INST_SB]  ? MOP_SB  :
           inst[INST_SH]  ? MOP_SH  :
           inst[INST_SW]  ? MOP_SW  : MOP_NONE;
  endfunction
  function automatic logic is_load(input memop_t op);
    return op inside {MOP_LB, MOP_LH, MOP_LW, MOP_LBU, MOP_LHU};
  endfunction
endpackage

// File: rtl/mem_access_stage_lane.sv
// mem_lane_align: store strobe/lane replication, load lane extract with sign/zero
// extension, and misalignment detection.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  memop_t      i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_misalign = (i_op inside {MOP_LH, MOP_LHU, MOP_SH} && i_addr_lo[0]) ||
                 (i_op inside {MOP_LW, MOP_SW} && i_addr_lo != 2'b00);
    o_wstrb = i_op == MOP_SB ? 4'b0001 << i_addr_lo :
              i_op == MOP_SH ? 4'b0011 << {i_addr_lo[1], 1'b0} :
              i_op == MOP_SW ? 4'b1111 : 4'b0000;
    o_wdata = i_op == MOP_SB ? {4{i_store_data[7:0]}} :
              i_op == MOP_SH ? {2{i_store_data[15:0]}} : i_store_data;
    o_load_data = i_op == MOP_LB  ? {{24{w_byte[7]}}, w_byte} :
                  i_op == MOP_LBU ? {24'b0, w_byte} :
                  i_op == MOP_LH  ? {{16{w_half[15]}}, w_half} :
                  i_op == MOP_LHU ? {16'b0, w_half} : i_rdata;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: runs loads/stores over a req/gnt/rvalid bus and emits one
// registered writeback packet per accepted execute packet.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int N_param        = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [INST_W-1:0]  Single_Instruction_i,
  input  logic [N_param-1:0] alu_result_i,
  input  logic [N_param-1:0] store_data_i,
  input  logic [4:0]         rd_i,
  input  logic               write_reg_file_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [N_param-1:0] mem_addr_o,
  output logic [N_param-1:0] mem_wdata_o,
  output logic [3:0]         mem_wstrb_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [N_param-1:0] mem_rdata_i,
  output logic               wb_valid_o,
  output logic               wb_we_o,
  output logic [4:0]         wb_rd_o,
  output logic [N_param-1:0] wb_data_o,
  output logic               misalign_o,
  output logic               timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t        r_state, w_next;
  memop_t        r_op, w_dec_op, w_op;
  logic [1:0]    r_addr_lo, w_lo;
  logic [4:0]    r_rd;
  logic          r_we;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_start, w_ld, w_done, w_tmo, w_misalign;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata, w_load_data;
  assign o_ready   = r_state == IDLE;
  assign w_dec_op  = decode_memop(Single_Instruction_i);
  assign w_accept  = i_valid & o_ready;
  // In IDLE the aligner looks at the incoming packet; otherwise at the latched one.
  assign w_op      = o_ready ? w_dec_op : r_op;
  assign w_lo      = o_ready ? alu_result_i[1:0] : r_addr_lo;
  assign w_ld      = is_load(w_op);
  assign w_start   = w_accept & (w_dec_op != MOP_NONE) & ~w_misalign;
  assign w_done    = (r_state == REQ & mem_gnt_i & (~w_ld | mem_rvalid_i)) |
                     (r_state == WAIT & mem_rvalid_i);
  assign w_tmo     = ~o_ready & ~w_done & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  mem_lane_align u_align (
    .i_op        (w_op),
    .i_addr_lo   (w_lo),
    .i_store_data(store_data_i),
    .i_rdata     (mem_rdata_i),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data),
    .o_misalign  (w_misalign)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)               w_next = w_start ? REQ : IDLE;
    else if (w_done | w_tmo)           w_next = IDLE;
    else if (r_state == REQ & mem_gnt_i) w_next = WAIT;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op        <= MOP_NONE;
      r_addr_lo   <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      wb_valid_o  <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      misalign_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
      r_cnt      <= o_ready ? '0 : r_cnt + 1'b1;
      if (w_accept) begin
        r_op      <= w_dec_op;
        r_addr_lo <= alu_result_i[1:0];
        r_rd      <= rd_i;
        r_we      <= write_reg_file_i & (rd_i != 5'd0);
        if (w_start) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= ~is_load(w_dec_op);
          mem_addr_o  <= {alu_result_i[N_param-1:2], 2'b00};
          mem_wdata_o <= w_wdata;
          mem_wstrb_o <= w_wstrb;
        end else begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= rd_i;
          wb_we_o    <= (w_dec_op == MOP_NONE) & write_reg_file_i & (rd_i != 5'd0);
          misalign_o <= w_dec_op != MOP_NONE;
          if (w_dec_op == MOP_NONE) wb_data_o <= alu_result_i;
        end
      end
      if (w_done | w_tmo) begin
        mem_req_o  <= 1'b0;
        wb_valid_o <= 1'b1;
        wb_rd_o    <= r_rd;
        wb_we_o    <= w_done & w_ld & r_we;
        timeout_o  <= w_tmo;
        if (w_done & w_ld) wb_data_o <= w_load_data;
      end else if (r_state == REQ & mem_gnt_i) begin
        mem_req_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage against a
// behavioural model of the memory-stage rules, with a bench-driven bus responder.
module tb_mem_access_stage;
  import mem_stage_pkg::*;
  localparam int T = 8;
  logic        i_clk = 0, i_rst_n = 0, i_valid = 0, o_ready;
  logic [63:0] Single_Instruction_i = '0;
  logic [31:0] alu_result_i = '0, store_data_i = '0, mem_rdata_i = '0;
  logic [4:0]  rd_i = '0, wb_rd_o;
  logic        write_reg_file_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic        mem_req_o, mem_we_o, wb_valid_o, wb_we_o, misalign_o, timeout_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
  logic [3:0]  mem_wstrb_o;
  int          n_checks = 0, n_err = 0;
  logic [31:0] exp_data = '0;
  mem_access_stage #(.N_param(32), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .Single_Instruction_i(Single_Instruction_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .rd_i(rd_i), .write_reg_file_i(write_reg_file_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  // k: 0 ADD, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW, 9 all-zero code
  function automatic logic [63:0] code_of(input int k);
    logic [63:0] c;
    c = '0;
    case (k)
      0: c[INST_ADD] = 1'b1;
      1: c[INST_LB]  = 1'b1;
      2: c[INST_LH]  = 1'b1;
      3: c[INST_LW]  = 1'b1;
      4: c[INST_LBU] = 1'b1;
      5: c[INST_LHU] = 1'b1;
      6: c[INST_SB]  = 1'b1;
      7: c[INST_SH]  = 1'b1;
      8: c[INST_SW]  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction
  function automatic int size_of(input int k);
    return (k == 1 || k == 4 || k == 6) ? 1 : (k == 2 || k == 5 || k == 7) ? 2 : 4;
  endfunction
  // gd: request cycles before gnt; rvd: cycles from gnt to rvalid (0 = same cycle)
  task automatic run_op(input int k, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input logic [4:0] rd, input logic we,
                        input int gd, input int rvd);
    bit ld, st, mis, tmo, seen;
    int nreq, gc, exp_req;
    logic [31:0] b, h, e_load, e_wdata;
    logic [3:0] e_strb;
    ld  = k >= 1 && k <= 5;
    st  = k >= 6 && k <= 8;
    mis = (ld || st) && (addr % size_of(k) != 0);
    tmo = (ld || st) && !mis && (st ? gd > T - 1 : gd + rvd > T - 1);
    b = (rdata >> (8 * (addr % 4))) % 256;
    h = (rdata >> (16 * ((addr % 4) / 2))) % 65536;
    e_load = k == 1 ? (b >= 128 ? b - 32'd256 : b) :
             k == 2 ? (h >= 32768 ? h - 32'd65536 : h) :
             k == 4 ? b : k == 5 ? h : rdata;
    e_strb  = k == 6 ? 4'(1 << (addr % 4)) : k == 7 ? 4'(3 << (addr % 4)) : 4'hF;
    e_wdata = k == 6 ? (sd % 256) * 32'h01010101 : k == 7 ? (sd % 65536) * 32'h00010001 : sd;
    exp_req = (!(ld || st) || mis) ? 0 : (gd >= T) ? T : gd + 1;
    Single_Instruction_i = code_of(k);
    alu_result_i = addr; store_data_i = sd; rd_i = rd; write_reg_file_i = we;
    mem_rdata_i = rdata; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    Single_Instruction_i = '0;
    nreq = 0; gc = -1; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (wb_valid_o) begin
        seen = 1;
        break;
      end
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (mem_req_o) begin
        chk("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        chk("mem_we", 32'(mem_we_o), 32'(st));
        if (st) begin
          chk("mem_wstrb", 32'(mem_wstrb_o), 32'(e_strb));
          chk("mem_wdata", mem_wdata_o, e_wdata);
        end
        if (nreq == gd) begin
          mem_gnt_i = 1'b1;
          gc = i;
        end
        nreq++;
      end
      if (ld && gc >= 0 && i - gc == rvd) mem_rvalid_i = 1'b1;
      step();
    end
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    chk("wb_seen", 32'(seen), 32'd1);
    if (!mis && !tmo && (ld || !(ld || st))) exp_data = ld ? e_load : addr;
    chk("req_cycles", nreq, exp_req);
    chk("wb_rd", 32'(wb_rd_o), 32'(rd));
    chk("wb_we", 32'(wb_we_o), 32'(!(st || mis || tmo) && we && rd != 0));
    chk("wb_data", wb_data_o, exp_data);
    chk("misalign", 32'(misalign_o), 32'(mis));
    chk("timeout", 32'(timeout_o), 32'(tmo));
    chk("ready_at_wb", 32'(o_ready), 32'd1);
    step();
    chk("wb_pulse_end", 32'(wb_valid_o | misalign_o | timeout_o), 32'd0);
    chk("wb_hold", wb_data_o, exp_data);
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_strb", 32'(mem_wstrb_o), 32'd0);
    i_rst_n = 1'b1;
    step();
    run_op(0, 32'h1234, 0, 0, 5'd5, 1'b1, 0, 0);
    chk("add_data", wb_data_o, 32'h1234);
    run_op(0, 32'h1234, 0, 0, 5'd0, 1'b1, 0, 0);
    run_op(1, 32'h103, 0, 32'h80AABBCC, 5'd7, 1'b1, 0, 0);
    chk("lb_data", wb_data_o, 32'hFFFFFF80);
    run_op(4, 32'h103, 0, 32'h80AABBCC, 5'd7, 1'b1, 0, 0);
    chk("lbu_data", wb_data_o, 32'h00000080);
    run_op(7, 32'h202, 32'h0000BEEF, 0, 5'd3, 1'b1, 3, 0);
    run_op(3, 32'h101, 0, 0, 5'd4, 1'b1, 0, 0);
    run_op(3, 32'h400, 0, 32'hDEADBEEF, 5'd4, 1'b1, 100, 0);
    run_op(3, 32'h400, 0, 32'hCAFEF00D, 5'd9, 1'b1, 2, 3);
    run_op(2, 32'h102, 0, 32'h8001_7FFF, 5'd2, 1'b1, 1, 6);
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) begin
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        step();
        chk("stray_idle", 32'(wb_valid_o | mem_req_o), 32'd0);
      end
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op($urandom_range(0, 9), a, $urandom(), $urandom(), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 4),
             $urandom_range(0, 4));
    end
    run_op(0, 32'h55AA, 0, 0, 5'd1, 1'b1, 0, 0);
    Single_Instruction_i = code_of(3);
    alu_result_i = 32'h800; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("wait_req_low", 32'(mem_req_o), 32'd0);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_wb", 32'(wb_valid_o), 32'd0);
    chk("rst_mid_ready", 32'(o_ready), 32'd1);
    chk("rst_mid_data", wb_data_o, 32'd0);
    step();
    i_rst_n = 1'b1;
    mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    step();
    chk("late_rvalid", 32'(wb_valid_o), 32'd0);
    exp_data = '0;
    Single_Instruction_i = code_of(8);
    alu_result_i = 32'h900; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("req_before_rst", 32'(mem_req_o), 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_in_req", 32'(mem_req_o), 32'd0);
    step();
    i_rst_n = 1'b1;
    step();
    run_op(8, 32'hA04, 32'h12345678, 0, 5'd6, 1'b1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
